// File: rtl/wb_hp_poller_if.sv
// Wishbone classic bus bundle between the hoggephase poller (master) and the
// detector register (slave).
//   wbm_cyc_o / wbm_stb_o : bus cycle and strobe, driven by the master
//   wbm_we_o              : 1 = write, 0 = read
//   wbm_adr_o             : byte address of the target register
//   wbm_dat_o             : write data
//   wbm_sel_o             : byte selects
//   wbm_ack_i             : slave acknowledge
//   wbm_dat_i             : read data
interface wb_hp_poller_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/wb_hp_poller.sv
// Wishbone classic initiator for the hoggephase detector control/status
// register. Sends queued configuration writes, polls the status register at a
// fixed interval, and turns alarm-counter changes and alarm-latch rising edges
// into 16-bit event records held in a small FIFO.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   enable        : polling runs while high
//   cfg_wr        : pulse, queue a write of cfg_data (unused bits sent as 0)
//   cfg_data      : [0]vcc [1]alarm_rst [2]ctr_rst [3]glitch_en [15:14]pn_select
//   cfg_busy      : a configuration write is pending or in progress
//   wbm           : Wishbone master bus bundle
//   evt_valid     : event FIFO not empty
//   evt_ready     : consumer pops the head entry
//   evt_data      : head entry {delta[7:0], ctr[7:0]}, 0 when empty
//   status_o      : low half of the last successfully read status word
//   evt_overflow  : sticky, an event was dropped because the FIFO was full
//   timeout_o     : sticky, a transfer was aborted without ack
//   err_clr       : clears both sticky flags (a same-cycle set wins)
module wb_hp_poller #(
  parameter logic [31:0] TARGET_ADDR = 32'h3000_0000,
  parameter int          POLL_DIV    = 64,
  parameter int          TIMEOUT     = 15,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 cfg_wr,
  input  logic [15:0]          cfg_data,
  output logic                 cfg_busy,
  wb_hp_poller_if.master       wbm,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [15:0]          evt_data,
  output logic [15:0]          status_o,
  output logic                 evt_overflow,
  output logic                 timeout_o,
  input  logic                 err_clr
);

  localparam int TW   = $clog2(POLL_DIV + 1);
  localparam int CW   = $clog2(TIMEOUT + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  // Only vcc, alarm_rst, ctr_rst, glitch_en and pn_select reach the bus.
  localparam logic [15:0] CFG_MASK = 16'hC00F;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_WRITE, S_READ, S_EVAL
  } state_t;

  state_t state_reg, state_next;

  logic [TW-1:0] timer_reg;
  logic [CW-1:0] to_cnt_reg;
  logic          pend_reg;
  logic [15:0]   pend_data_reg;
  logic [15:0]   rd_data_reg;
  logic [7:0]    last_ctr_reg;
  logic          last_latch_reg;
  logic [15:0]   status_reg;
  logic          overflow_reg;
  logic          timeout_reg;

  logic in_xfer;
  logic ack_seen;
  logic to_expire;

  assign in_xfer   = (state_reg == S_WRITE) || (state_reg == S_READ);
  assign ack_seen  = in_xfer && wbm.wbm_ack_i;
  // The counter holds the number of strobe cycles already spent; the abort
  // fires in the last allowed cycle so strobe is high exactly TIMEOUT cycles.
  assign to_expire = in_xfer && !wbm.wbm_ack_i && (to_cnt_reg == CW'(TIMEOUT - 1));

  // Upper half of the read word carries nothing this block uses.
  logic unused_dat_hi;
  assign unused_dat_hi = ^wbm.wbm_dat_i[31:16];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (pend_reg)    state_next = S_WRITE;
        else if (enable) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (pend_reg)               state_next = S_WRITE;
        else if (!enable)           state_next = S_IDLE;
        else if (timer_reg == '0)   state_next = S_READ;
      end
      S_WRITE: begin
        if (ack_seen || to_expire) state_next = S_IDLE;
      end
      S_READ: begin
        if (ack_seen)       state_next = S_EVAL;
        else if (to_expire) state_next = S_IDLE;
      end
      S_EVAL:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Bus outputs decode straight from the state, so a transfer's attributes are
  // constant for its whole life and vanish the cycle after ack or abort.
  always_comb begin
    wbm.wbm_cyc_o = in_xfer;
    wbm.wbm_stb_o = in_xfer;
    wbm.wbm_we_o  = (state_reg == S_WRITE);
    wbm.wbm_adr_o = in_xfer ? TARGET_ADDR : 32'h0;
    wbm.wbm_sel_o = in_xfer ? 4'hF : 4'h0;
    wbm.wbm_dat_o = (state_reg == S_WRITE) ? {16'h0, pend_data_reg} : 32'h0;
  end

  // ---------------------------------------------------------- datapath
  // IDLE and the WAIT->READ step each take one cycle of the interval, so WAIT
  // itself counts POLL_DIV-2 down to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_reg <= TW'(POLL_DIV);
    end else if (state_reg == S_IDLE) begin
      timer_reg <= TW'(POLL_DIV - 2);
    end else if (state_reg == S_WAIT && timer_reg != '0) begin
      timer_reg <= timer_reg - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !in_xfer || wbm.wbm_ack_i) to_cnt_reg <= '0;
    else                                    to_cnt_reg <= to_cnt_reg + CW'(1);
  end

  // One-entry write queue. Once WRITE is entered the data is frozen, and a
  // cfg_wr arriving during the write (including its final cycle) is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_reg      <= 1'b0;
      pend_data_reg <= 16'h0;
    end else if (state_reg == S_WRITE) begin
      if (ack_seen || to_expire) pend_reg <= 1'b0;
    end else if (cfg_wr) begin
      pend_reg      <= 1'b1;
      pend_data_reg <= cfg_data & CFG_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                rd_data_reg <= 16'h0;
    else if (state_reg == S_READ && ack_seen) rd_data_reg <= wbm.wbm_dat_i[15:0];
  end

  // ------------------------------------------------------------- EVAL
  logic [7:0] ev_ctr;
  logic [7:0] ev_delta;
  logic       ev_latch;
  logic       push;

  assign ev_ctr   = rd_data_reg[13:6];
  assign ev_latch = rd_data_reg[5];
  assign ev_delta = ev_ctr - last_ctr_reg;  // wraps mod 256 on counter reset
  assign push     = (state_reg == S_EVAL) &&
                    ((ev_delta != 8'h0) || (ev_latch && !last_latch_reg));

  always_ff @(posedge clk) begin
    if (reset) begin
      status_reg     <= 16'h0;
      last_ctr_reg   <= 8'h0;
      last_latch_reg <= 1'b0;
    end else if (state_reg == S_EVAL) begin
      status_reg     <= rd_data_reg;
      last_ctr_reg   <= ev_ctr;
      last_latch_reg <= ev_latch;
    end
  end

  // ------------------------------------------------------------- FIFO
  logic [15:0]     fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CNTW-1:0] count_reg;
  logic            full;
  logic            pop;
  logic            push_ok;

  assign full    = (count_reg == CNTW'(FIFO_DEPTH));
  assign pop     = (count_reg != '0) && evt_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= {ev_delta, ev_ctr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CNTW'(push_ok) - CNTW'(pop);
    end
  end

  // ------------------------------------------------------ sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      if (push && full && !pop) overflow_reg <= 1'b1;
      else if (err_clr)         overflow_reg <= 1'b0;
      if (to_expire)            timeout_reg  <= 1'b1;
      else if (err_clr)         timeout_reg  <= 1'b0;
    end
  end

  assign cfg_busy     = pend_reg;
  assign evt_valid    = (count_reg != '0);
  assign evt_data     = evt_valid ? fifo_mem[rd_ptr_reg] : 16'h0;
  assign status_o     = status_reg;
  assign evt_overflow = overflow_reg;
  assign timeout_o    = timeout_reg;

endmodule

// File: tb/tb_wb_hp_poller.sv
// Self-checking bench for wb_hp_poller: a Wishbone responder model, a table of
// poll vectors with hand-computed events, and directed sequences for the
// configuration write, ack timeout, FIFO overflow and mid-transfer reset.
module tb_wb_hp_poller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [15:0] cfg_data = 16'h0;
  logic        evt_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic        cfg_busy;
  logic        evt_valid;
  logic [15:0] evt_data;
  logic [15:0] status_o;
  logic        evt_overflow;
  logic        timeout_o;

  wb_hp_poller_if wb();

  wb_hp_poller dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .cfg_wr       (cfg_wr),
    .cfg_data     (cfg_data),
    .cfg_busy     (cfg_busy),
    .wbm          (wb),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_data     (evt_data),
    .status_o     (status_o),
    .evt_overflow (evt_overflow),
    .timeout_o    (timeout_o),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  // Responder: acks one cycle after strobe rises, unless muted.
  logic        mute = 1'b0;
  logic [31:0] resp_data = 32'h0;
  int          rd_count = 0;

  always @(posedge clk) begin
    if (reset) begin
      wb.wbm_ack_i <= 1'b0;
      wb.wbm_dat_i <= 32'h0;
    end else begin
      if (wb.wbm_cyc_o && wb.wbm_stb_o && wb.wbm_ack_i && !wb.wbm_we_o)
        rd_count <= rd_count + 1;
      wb.wbm_ack_i <= wb.wbm_cyc_o && wb.wbm_stb_o && !wb.wbm_ack_i && !mute;
      wb.wbm_dat_i <= (wb.wbm_cyc_o && wb.wbm_stb_o && !wb.wbm_ack_i && !mute)
                      ? resp_data : 32'h0;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Counts negedges until cyc is seen, giving up after budget.
  task automatic wait_cyc(input int budget, output int n);
    n = 0;
    while (!wb.wbm_cyc_o && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Waits for the next acked read, then for EVAL and its registered results.
  task automatic wait_read(output logic ok);
    int target;
    int n;
    target = rd_count + 1;
    n = 0;
    while (rd_count < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (rd_count >= target);
    @(negedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] word;
    logic        ev;
    logic [15:0] ev_data;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] ctr, input logic latch, input logic alarm,
                              input logic noise, input logic ev, input logic [15:0] ev_data);
    vec_t v;
    v.word    = noise ? {16'h5A5A, 2'b01, ctr, latch, alarm, 4'h6}
                      : {16'h0, 2'b00, ctr, latch, alarm, 4'h0};
    v.ev      = ev;
    v.ev_data = ev_data;
    return v;
  endfunction

  vec_t vecs [8];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   hi;
    logic ok;

    vecs[0] = mk(8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    vecs[1] = mk(8'd3,   1'b1, 1'b1, 1'b1, 1'b1, 16'h0303);
    vecs[2] = mk(8'd3,   1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    vecs[3] = mk(8'd3,   1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    vecs[4] = mk(8'd3,   1'b1, 1'b0, 1'b1, 1'b1, 16'h0003);
    vecs[5] = mk(8'd250, 1'b1, 1'b1, 1'b1, 1'b1, 16'hF7FA);
    vecs[6] = mk(8'd4,   1'b1, 1'b0, 1'b0, 1'b1, 16'h0A04);
    vecs[7] = mk(8'd4,   1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

    // Reset state
    resp_data = vecs[0].word;
    repeat (3) @(negedge clk);
    check("rst cyc/stb/we", {29'h0, wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o}, 32'h0);
    check("rst adr", wb.wbm_adr_o, 32'h0);
    check("rst dat_o", wb.wbm_dat_o, 32'h0);
    check("rst sel", {28'h0, wb.wbm_sel_o}, 32'h0);
    check("rst flags", {28'h0, cfg_busy, evt_valid, evt_overflow, timeout_o}, 32'h0);
    check("rst evt_data", evt_data, 32'h0);
    check("rst status", status_o, 32'h0);

    // First poll timing and attributes
    reset  = 1'b0;
    enable = 1'b1;
    wait_cyc(200, n);
    check("first read cycle", n, 64);
    check("read we", wb.wbm_we_o, 1'b0);
    check("read stb", wb.wbm_stb_o, 1'b1);
    check("read adr", wb.wbm_adr_o, 32'h3000_0000);
    check("read sel", wb.wbm_sel_o, 4'hF);

    // Table-driven polls
    for (int i = 0; i < 8; i++) begin
      resp_data = vecs[i].word;
      wait_read(ok);
      check($sformatf("v%0d read done", i), ok, 1'b1);
      check($sformatf("v%0d status", i), status_o, vecs[i].word[15:0]);
      check($sformatf("v%0d evt_valid", i), evt_valid, vecs[i].ev);
      check($sformatf("v%0d evt_data", i), evt_data, vecs[i].ev ? vecs[i].ev_data : 16'h0);
      if (vecs[i].ev) begin
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        check($sformatf("v%0d popped valid", i), evt_valid, 1'b0);
        check($sformatf("v%0d popped data", i), evt_data, 16'h0);
      end
    end

    // Configuration write preempting WAIT
    repeat (5) @(negedge clk);
    cfg_data = 16'hC3F9;
    cfg_wr   = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    check("cfg_busy rise", cfg_busy, 1'b1);
    wait_cyc(10, n);
    check("write preempt delay", n, 1);
    check("write we", wb.wbm_we_o, 1'b1);
    check("write dat_o", wb.wbm_dat_o, 32'h0000_C009);
    check("write adr", wb.wbm_adr_o, 32'h3000_0000);
    check("write sel", wb.wbm_sel_o, 4'hF);
    @(negedge clk);
    check("write ack cycle", {30'h0, wb.wbm_ack_i, wb.wbm_cyc_o}, 32'h3);
    @(negedge clk);
    check("write done cyc", wb.wbm_cyc_o, 1'b0);
    check("cfg_busy clear", cfg_busy, 1'b0);
    wait_cyc(200, n);
    check("poll gap after write", n, 64);
    check("poll after write we", wb.wbm_we_o, 1'b0);
    wait_read(ok);
    check("poll after write done", ok, 1'b1);
    check("poll after write no evt", evt_valid, 1'b0);

    // Ack timeout
    mute = 1'b1;
    wait_cyc(200, n);
    check("timeout xfer start", n < 200, 1'b1);
    hi = 0;
    while (wb.wbm_stb_o && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    check("timeout stb cycles", hi, 15);
    check("timeout cyc drop", wb.wbm_cyc_o, 1'b0);
    check("timeout_o set", timeout_o, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("timeout_o cleared", timeout_o, 1'b0);
    mute = 1'b0;
    wait_read(ok);
    check("polling resumed", ok, 1'b1);
    check("timeout status kept", status_o, vecs[7].word[15:0]);

    // Five events into a four-entry FIFO
    for (int j = 1; j <= 5; j++) begin
      resp_data = {18'h0, 8'(4 + j), 6'h0};
      wait_read(ok);
      check($sformatf("ovf poll%0d done", j), ok, 1'b1);
      check($sformatf("ovf poll%0d overflow", j), evt_overflow, j == 5);
      check($sformatf("ovf poll%0d valid", j), evt_valid, 1'b1);
    end
    check("ovf head", evt_data, 16'h0105);

    // Reset in the middle of a read
    wait_cyc(200, n);
    check("mid read start", {31'h0, wb.wbm_cyc_o & ~wb.wbm_we_o}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("mrst cyc/stb/we", {29'h0, wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o}, 32'h0);
    check("mrst adr/sel", {wb.wbm_adr_o[27:0], wb.wbm_sel_o}, 32'h0);
    check("mrst flags", {28'h0, cfg_busy, evt_valid, evt_overflow, timeout_o}, 32'h0);
    check("mrst evt_data", evt_data, 16'h0);
    check("mrst status", status_o, 16'h0);
    reset = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
